// File: rtl/nibbler_pkg.sv
// Shared types and opcode constants for the nibbler sequencer.
// The optional single-step feature is selected with the SINGLE_STEP_EN macro in nibbler_seq_ctrl.
package nibbler_pkg;

  // FSM state encoding; also exported on the phase port.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    HALT    = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_JC  = 4'h1;
  localparam logic [3:0] OP_JNZ = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h3;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Any opcode outside the control group goes through the ALU and writes ACC and flags.
  function automatic logic is_alu_op(input logic [3:0] op);
    return !(op inside {OP_NOP, OP_JC, OP_JNZ, OP_JMP, OP_HLT});
  endfunction

  function automatic logic is_hlt_op(input logic [3:0] op);
    return (op == OP_HLT);
  endfunction

endpackage

// File: rtl/nibbler_jump_unit.sv
// Combinational instruction classifier: branch decision plus ALU/HLT class flags.
module nibbler_jump_unit
  import nibbler_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  logic       carry_i,
  input  logic       zero_i,
  output logic       take_o,
  output logic       is_alu_o,
  output logic       is_hlt_o
);

  // Conditional jumps test the flags; JMP always takes.
  always_comb begin
    take_o   = ((opcode_i == OP_JC)  &  carry_i) |
               ((opcode_i == OP_JNZ) & ~zero_i)  |
                (opcode_i == OP_JMP);
    is_alu_o = is_alu_op(opcode_i);
    is_hlt_o = is_hlt_op(opcode_i);
  end

endmodule

// File: rtl/nibbler_seq_ctrl.sv
// Instruction sequencer for the 4-bit datapath: fetch handshake, decode, execute enables,
// retired-instruction counter.
// Build option: SINGLE_STEP_EN enables the edge-armed single-step start from IDLE.
//
// state   | meaning
// IDLE    | waiting for run (or an armed step)
// FETCH   | mem_req high, waiting for mem_ready; IR loads in the ready cycle
// DECODE  | one cycle, jump decision and op class registered
// EXECUTE | one cycle of PC/ACC/flags enables, instruction retires
// HALT    | HLT retired; only reset leaves
module nibbler_seq_ctrl
  import nibbler_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             mem_ready,
  input  logic [3:0]       opcode,
  input  logic             carry,
  input  logic             zero,
  output logic             mem_req,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             acc_load,
  output logic             flags_load,
  output logic [2:0]       phase,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t           state_q;
  logic             mem_req_q;
  logic             pc_inc_q;
  logic             pc_load_q;
  logic             alu_load_q;
  logic             halted_q;
  logic             hlt_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             start;
  logic             take;
  logic             is_alu;
  logic             is_hlt;

  nibbler_jump_unit u_jump (
    .opcode_i (opcode),
    .carry_i  (carry),
    .zero_i   (zero),
    .take_o   (take),
    .is_alu_o (is_alu),
    .is_hlt_o (is_hlt)
  );

`ifdef SINGLE_STEP_EN
  logic step_armed_q;

  // Re-arm on any low sample of step; consume the arm when a step starts an instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_armed_q <= 1'b0;
    end else if (!step) begin
      step_armed_q <= 1'b1;
    end else if ((state_q == IDLE) && !run && step_armed_q) begin
      step_armed_q <= 1'b0;
    end
  end

  // Start when free-running, or on an armed step while run is low.
  always_comb begin
    start = run | (step & step_armed_q);
  end
`else
  logic unused_step;

  // step has no function in this build; it is kept only on the port list.
  always_comb begin
    start       = run;
    unused_step = step;
  end
`endif

  // Counter wraps naturally at 2^CNT_W.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
  end

  // Sequencer FSM; enables are registered so they follow the state with no input path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      pc_inc_q   <= 1'b0;
      pc_load_q  <= 1'b0;
      alu_load_q <= 1'b0;
      halted_q   <= 1'b0;
      hlt_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      mem_req_q  <= 1'b0;
      pc_inc_q   <= 1'b0;
      pc_load_q  <= 1'b0;
      alu_load_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= FETCH;
            mem_req_q <= 1'b1;
          end
        end
        FETCH: begin
          if (mem_ready) begin
            state_q <= DECODE;
          end else begin
            mem_req_q <= 1'b1;
          end
        end
        DECODE: begin
          state_q    <= EXECUTE;
          pc_load_q  <= take;
          pc_inc_q   <= ~take & ~is_hlt;
          alu_load_q <= is_alu;
          hlt_q      <= is_hlt;
        end
        EXECUTE: begin
          cnt_q <= cnt_d;
          if (hlt_q) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else if (run) begin
            state_q   <= FETCH;
            mem_req_q <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // IR load is the one output allowed to follow mem_ready within the cycle.
  always_comb begin
    mem_req    = mem_req_q;
    ir_load    = (state_q == FETCH) & mem_ready;
    pc_inc     = pc_inc_q;
    pc_load    = pc_load_q;
    acc_load   = alu_load_q;
    flags_load = alu_load_q;
    phase      = state_q;
    halted     = halted_q;
    instr_cnt  = cnt_q;
  end

endmodule
